// File: rtl/zx_key_matrix.sv
// ZX Spectrum keyboard matrix fed by PS/2 set-2 key events, with a minimum
// visible hold time (deferred-release queue) and NMI / reset hotkey decode.
module zx_key_matrix #(
  parameter int MIN_HOLD = 1400000,
  parameter int RQ_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       key_strobe,
  input  logic       key_pressed,
  input  logic       key_extended,
  input  logic [7:0] key_code,
  input  logic [7:0] addr_hi,
  output logic [4:0] key_data,
  output logic       nmi_req,
  output logic       reset_req,
  output logic       queue_ovf
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = $clog2(RQ_DEPTH + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(RQ_DEPTH);

  // Held index = row*5 + column for the 40 matrix positions (CS=LShift,
  // SS=LCtrl); 40..46 are RShift, LAlt, Backspace, Up, Down, Left, Right.
  logic [46:0]         held;
  logic [HW-1:0]       hold_cnt;
  logic [5:0]          rq_idx [RQ_DEPTH];
  logic [RQ_DEPTH-1:0] rq_vld;
  logic [RQ_DEPTH-1:0] void_hit;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       rq_cnt;

  logic       map_hit;
  logic [5:0] map_idx;

  always_comb begin
    map_hit = 1'b1;
    map_idx = 6'd0;
    if (key_extended) begin
      case (key_code)
        8'h75: map_idx = 6'd43;
        8'h72: map_idx = 6'd44;
        8'h6B: map_idx = 6'd45;
        8'h74: map_idx = 6'd46;
        default: map_hit = 1'b0;
      endcase
    end else begin
      case (key_code)
        8'h12: map_idx = 6'd0;   8'h1A: map_idx = 6'd1;   8'h22: map_idx = 6'd2;
        8'h21: map_idx = 6'd3;   8'h2A: map_idx = 6'd4;
        8'h1C: map_idx = 6'd5;   8'h1B: map_idx = 6'd6;   8'h23: map_idx = 6'd7;
        8'h2B: map_idx = 6'd8;   8'h34: map_idx = 6'd9;
        8'h15: map_idx = 6'd10;  8'h1D: map_idx = 6'd11;  8'h24: map_idx = 6'd12;
        8'h2D: map_idx = 6'd13;  8'h2C: map_idx = 6'd14;
        8'h16: map_idx = 6'd15;  8'h1E: map_idx = 6'd16;  8'h26: map_idx = 6'd17;
        8'h25: map_idx = 6'd18;  8'h2E: map_idx = 6'd19;
        8'h45: map_idx = 6'd20;  8'h46: map_idx = 6'd21;  8'h3E: map_idx = 6'd22;
        8'h3D: map_idx = 6'd23;  8'h36: map_idx = 6'd24;
        8'h4D: map_idx = 6'd25;  8'h44: map_idx = 6'd26;  8'h43: map_idx = 6'd27;
        8'h3C: map_idx = 6'd28;  8'h35: map_idx = 6'd29;
        8'h5A: map_idx = 6'd30;  8'h4B: map_idx = 6'd31;  8'h42: map_idx = 6'd32;
        8'h3B: map_idx = 6'd33;  8'h33: map_idx = 6'd34;
        8'h29: map_idx = 6'd35;  8'h14: map_idx = 6'd36;  8'h3A: map_idx = 6'd37;
        8'h31: map_idx = 6'd38;  8'h32: map_idx = 6'd39;
        8'h59: map_idx = 6'd40;  8'h11: map_idx = 6'd41;  8'h66: map_idx = 6'd42;
        default: map_hit = 1'b0;
      endcase
    end
  end

  logic ev_press, ev_release, hold_zero, rq_empty, rq_full;
  logic do_pop, do_push, rel_now;

  assign ev_press   = key_strobe && key_pressed && map_hit;
  assign ev_release = key_strobe && !key_pressed && map_hit;
  assign hold_zero  = (hold_cnt == '0);
  assign rq_empty   = (rq_cnt == '0);
  assign rq_full    = (rq_cnt == CNT_FULL);
  assign do_pop     = hold_zero && !rq_empty;
  assign rel_now    = ev_release && ((hold_zero && rq_empty) || rq_full);
  assign do_push    = ev_release && !rel_now;

  for (genvar g = 0; g < RQ_DEPTH; g++) begin : g_void
    assign void_hit[g] = ev_press && (rq_idx[g] == map_idx);
  end

  // Entry payload needs no reset: it is only ever read behind its valid bit.
  always_ff @(posedge clk_sys) begin
    if (do_push) rq_idx[wr_ptr] <= map_idx;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      held      <= '0;
      hold_cnt  <= '0;
      rq_vld    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rq_cnt    <= '0;
      nmi_req   <= 1'b0;
      reset_req <= 1'b0;
      queue_ovf <= 1'b0;
    end else begin
      nmi_req   <= key_strobe && key_pressed && !key_extended && (key_code == 8'h03);
      reset_req <= key_strobe && key_pressed && key_extended && (key_code == 8'h71)
                   && held[36] && held[41];

      if (ev_press)       hold_cnt <= HOLD_LOAD;
      else if (!hold_zero) hold_cnt <= hold_cnt - HOLD_ONE;

      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (rq_vld[rd_ptr]) held[rq_idx[rd_ptr]] <= 1'b0;
      end
      if (do_push) begin
        rq_vld[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + PTR_ONE;
      end
      if (rel_now) begin
        held[map_idx] <= 1'b0;
        if (rq_full) queue_ovf <= 1'b1;
      end
      // A press is applied last so it wins over a same-cycle pop of its own key.
      if (ev_press) begin
        held[map_idx] <= 1'b1;
        rq_vld        <= rq_vld & ~void_hit;
      end

      case ({do_push, do_pop})
        2'b10:   rq_cnt <= rq_cnt + CNT_ONE;
        2'b01:   rq_cnt <= rq_cnt - CNT_ONE;
        default: rq_cnt <= rq_cnt;
      endcase
    end
  end

  logic [7:0][4:0] matrix;

  always_comb begin
    matrix       = held[39:0];
    matrix[0][0] = held[0] | held[40] | held[42] | held[43] | held[44] | held[45] | held[46];
    matrix[7][1] = held[36] | held[41];
    matrix[4][0] = held[20] | held[42];
    matrix[4][2] = held[22] | held[46];
    matrix[4][3] = held[23] | held[43];
    matrix[4][4] = held[24] | held[44];
    matrix[3][4] = held[19] | held[45];
  end

  assign key_data = ~(({5{~addr_hi[0]}} & matrix[0]) | ({5{~addr_hi[1]}} & matrix[1]) |
                      ({5{~addr_hi[2]}} & matrix[2]) | ({5{~addr_hi[3]}} & matrix[3]) |
                      ({5{~addr_hi[4]}} & matrix[4]) | ({5{~addr_hi[5]}} & matrix[5]) |
                      ({5{~addr_hi[6]}} & matrix[6]) | ({5{~addr_hi[7]}} & matrix[7]));

endmodule
